// File: rtl/axi_gpio_irq.sv
// axi_gpio_irq: parametrised GPIO on an AXI-Lite-style slave with input synchroniser and edge IRQs.
// Optional byte-lane write strobes: define AXI_GPIO_WSTRB_EN to add the s_wstrb port.
module axi_gpio_irq #(
    parameter int GPIO_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic              s_wvalid,
`ifdef AXI_GPIO_WSTRB_EN
    input  logic [3:0]        s_wstrb,
`endif
    output logic              s_wready,
    output logic              s_bvalid,
    output logic [1:0]        s_bresp,
    input  logic              s_bready,
    input  logic [31:0]       s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              irq
);
    localparam logic [2:0] REG_IN   = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_DIR  = 3'd2;
    localparam logic [2:0] REG_SET  = 3'd3;
    localparam logic [2:0] REG_CLR  = 3'd4;
    localparam logic [2:0] REG_RISE = 3'd5;
    localparam logic [2:0] REG_FALL = 3'd6;
    localparam logic [2:0] REG_STAT = 3'd7;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_r;
    logic [GPIO_W-1:0] prev_r;
    logic [GPIO_W-1:0] out_r;
    logic [GPIO_W-1:0] dir_r;
    logic [GPIO_W-1:0] rise_en_r;
    logic [GPIO_W-1:0] fall_en_r;
    logic [GPIO_W-1:0] stat_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic              rvalid_r;
    logic [1:0]        rresp_r;
    logic [31:0]       rdata_r;

    logic              wr_en_s;
    logic              rd_en_s;
    logic              wr_bad_s;
    logic              rd_bad_s;
    logic [31:0]       strb_mask_s;
    logic [GPIO_W-1:0] wd_s;
    logic [GPIO_W-1:0] wm_s;
    logic [GPIO_W-1:0] sync_s;
    logic [GPIO_W-1:0] rise_s;
    logic [GPIO_W-1:0] fall_s;
    logic [GPIO_W-1:0] w1c_s;
    logic [31:0]       rd_val_s;
    logic              unused_s;

    // Only the low window of the address space is mapped; misaligned or out-of-window is an error.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:5] != 27'd0);
    endfunction

    function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
        logic [31:0] r;
        r = 32'd0;
        r[GPIO_W-1:0] = v;
        return r;
    endfunction

`ifdef AXI_GPIO_WSTRB_EN
    assign strb_mask_s = {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}};
`else
    assign strb_mask_s = 32'hFFFF_FFFF;
`endif

    assign wm_s     = strb_mask_s[GPIO_W-1:0];
    assign wd_s     = s_wdata[GPIO_W-1:0] & wm_s;
    assign unused_s = ^{s_wdata, strb_mask_s};

    assign wr_en_s  = s_awvalid && s_wvalid && !bvalid_r;
    assign rd_en_s  = s_arvalid && !rvalid_r;
    assign wr_bad_s = addr_bad(s_awaddr);
    assign rd_bad_s = addr_bad(s_araddr);

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign rise_s = sync_s & ~prev_r & rise_en_r;
    assign fall_s = ~sync_s & prev_r & fall_en_r;

    assign s_awready = !bvalid_r;
    assign s_wready  = !bvalid_r;
    assign s_arready = !rvalid_r;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_rvalid  = rvalid_r;
    assign s_rresp   = rresp_r;
    assign s_rdata   = rdata_r;
    assign gpio_out  = out_r;
    assign gpio_oe   = dir_r;
    assign irq       = |stat_r;

    // W1C mask for IRQ_STAT, only from an accepted, mapped write
    always_comb begin
        w1c_s = '0;
        if (wr_en_s && !wr_bad_s && (s_awaddr[4:2] == REG_STAT)) begin
            w1c_s = wd_s;
        end else begin
            w1c_s = '0;
        end
    end

    // Read data mux; write-only and unmapped offsets return zero
    always_comb begin
        rd_val_s = 32'd0;
        case (s_araddr[4:2])
            REG_IN:   rd_val_s = zext(sync_s);
            REG_OUT:  rd_val_s = zext(out_r);
            REG_DIR:  rd_val_s = zext(dir_r);
            REG_RISE: rd_val_s = zext(rise_en_r);
            REG_FALL: rd_val_s = zext(fall_en_r);
            REG_STAT: rd_val_s = zext(stat_r);
            default:  rd_val_s = 32'd0;
        endcase
        if (rd_bad_s) begin
            rd_val_s = 32'd0;
        end else begin
            rd_val_s = rd_val_s;
        end
    end

    // Input synchroniser chain and edge-history register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], gpio_in};
            prev_r <= sync_s;
        end
    end

    // Register file; a new edge beats a same-cycle W1C on IRQ_STAT
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= '0;
            dir_r     <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            stat_r    <= '0;
        end else begin
            if (wr_en_s && !wr_bad_s) begin
                case (s_awaddr[4:2])
                    REG_OUT:  out_r     <= (out_r & ~wm_s) | wd_s;
                    REG_DIR:  dir_r     <= (dir_r & ~wm_s) | wd_s;
                    REG_SET:  out_r     <= out_r | wd_s;
                    REG_CLR:  out_r     <= out_r & ~wd_s;
                    REG_RISE: rise_en_r <= (rise_en_r & ~wm_s) | wd_s;
                    REG_FALL: fall_en_r <= (fall_en_r & ~wm_s) | wd_s;
                    default:  out_r     <= out_r;
                endcase
            end
            stat_r <= (stat_r & ~w1c_s) | rise_s | fall_s;
        end
    end

    // Write response channel
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_r <= 1'b0;
            bresp_r  <= RESP_OKAY;
        end else if (wr_en_s) begin
            bvalid_r <= 1'b1;
            bresp_r  <= wr_bad_s ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_r && s_bready) begin
            bvalid_r <= 1'b0;
        end
    end

    // Read data channel; data held until the R handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_r <= 1'b0;
            rresp_r  <= RESP_OKAY;
            rdata_r  <= 32'd0;
        end else if (rd_en_s) begin
            rvalid_r <= 1'b1;
            rresp_r  <= rd_bad_s ? RESP_SLVERR : RESP_OKAY;
            rdata_r  <= rd_val_s;
        end else if (rvalid_r && s_rready) begin
            rvalid_r <= 1'b0;
        end
    end
endmodule
